// File: rtl/vc32_rcache_pkg.sv
// Shared definitions for the vc32 read cache: word width, FSM states and
// the index/tag width helpers derived from the line count.
package vc32_rcache_pkg;

  localparam int RV_W = 16;
  localparam int AW   = 15;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MISS  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int lines);
    return AW - $clog2(lines);
  endfunction

endpackage

// File: rtl/vc32_rcache_if.sv
// Word-addressed split read/write request port; the CPU side and the
// downstream byte-serial sequencer side share this protocol.
interface vc32_rcache_if;

  logic [15:1]                         raddr;
  logic [1:0]                          rreq;
  logic [vc32_rcache_pkg::RV_W-1:0]    rdata;
  logic                                rdone;
  logic [15:1]                         waddr;
  logic [1:0]                          wmask;
  logic [vc32_rcache_pkg::RV_W-1:0]    wdata;
  logic                                wdone;

  modport master (
    output raddr, rreq, waddr, wmask, wdata,
    input  rdata, rdone, wdone
  );

  modport slave (
    input  raddr, rreq, waddr, wmask, wdata,
    output rdata, rdone, wdone
  );

endinterface

// File: rtl/vc32_rcache_store.sv
// Direct-mapped one-word line storage: combinational read lookup, fill port
// and byte-masked write-through update that only touches a hitting line.
module vc32_rcache_store
  import vc32_rcache_pkg::*;
#(
  parameter int DW    = RV_W,
  parameter int LINES = 8
) (
  input  logic          clk,
  input  logic          reset_in,
  input  logic          inv_i,
  input  logic [15:1]   rd_addr_i,
  output logic          rd_hit_o,
  output logic [DW-1:0] rd_data_o,
  input  logic          fill_en_i,
  input  logic          fill_valid_i,
  input  logic [15:1]   fill_addr_i,
  input  logic [DW-1:0] fill_data_i,
  input  logic          wr_en_i,
  input  logic [15:1]   wr_addr_i,
  input  logic [1:0]    wr_mask_i,
  input  logic [DW-1:0] wr_data_i
);

  localparam int IW = idx_w(LINES);
  localparam int TW = tag_w(LINES);

  logic [LINES-1:0] valid_q;
  logic [TW-1:0]    tag_q  [LINES];
  logic [DW-1:0]    data_q [LINES];

  logic [IW-1:0] rd_idx, fill_idx, wr_idx;
  logic          wr_hit;

  assign rd_idx   = rd_addr_i[IW:1];
  assign fill_idx = fill_addr_i[IW:1];
  assign wr_idx   = wr_addr_i[IW:1];

  assign rd_hit_o  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_addr_i[15:IW+1]);
  assign rd_data_o = data_q[rd_idx];
  assign wr_hit    = valid_q[wr_idx] && (tag_q[wr_idx] == wr_addr_i[15:IW+1]);

  always_ff @(posedge clk) begin
    if (reset_in || inv_i) begin
      valid_q <= '0;
    end else if (fill_en_i && fill_valid_i) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays carry no reset; valid_q alone decides whether they are used.
  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      tag_q[fill_idx]  <= fill_addr_i[15:IW+1];
      data_q[fill_idx] <= fill_data_i;
    end else if (wr_en_i && wr_hit) begin
      for (int b = 0; b < 2; b++) begin
        if (wr_mask_i[b]) data_q[wr_idx][8*b +: 8] <= wr_data_i[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/vc32_rcache.sv
// vc32 read cache: write-through/no-allocate, direct-mapped, one word per line.
// Owns the request FSM and every registered port output.
module vc32_rcache
  import vc32_rcache_pkg::*;
#(
  parameter int RV    = 16,
  parameter int LINES = 8
) (
  input  logic          clk,
  input  logic          reset_in,
  input  logic          inv,
  vc32_rcache_if.slave  cpu,
  vc32_rcache_if.master mem
);

  state_e         state_q;
  logic [RV-1:0]  rdata_q;
  logic           rdone_q, wdone_q, inv_seen_q;
  logic [15:1]    m_raddr_q, m_waddr_q;
  logic [1:0]     m_rreq_q, m_wmask_q;
  logic [RV-1:0]  m_wdata_q;

  logic           hit;
  logic [RV-1:0]  hit_data;
  logic           fill_en_d, fill_valid_d, wr_en_d;

  // An invalidate seen at any point of a miss keeps the refilled line invalid.
  assign fill_en_d    = (state_q == S_MISS) && mem.rdone && !reset_in;
  assign fill_valid_d = !(inv || inv_seen_q);
  assign wr_en_d      = (state_q == S_WRITE) && mem.wdone && !reset_in;

  vc32_rcache_store #(.DW(RV), .LINES(LINES)) u_store (
    .clk          (clk),
    .reset_in     (reset_in),
    .inv_i        (inv),
    .rd_addr_i    (cpu.raddr),
    .rd_hit_o     (hit),
    .rd_data_o    (hit_data),
    .fill_en_i    (fill_en_d),
    .fill_valid_i (fill_valid_d),
    .fill_addr_i  (m_raddr_q),
    .fill_data_i  (mem.rdata),
    .wr_en_i      (wr_en_d),
    .wr_addr_i    (m_waddr_q),
    .wr_mask_i    (m_wmask_q),
    .wr_data_i    (m_wdata_q)
  );

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state_q    <= S_IDLE;
      rdata_q    <= '0;
      rdone_q    <= 1'b0;
      wdone_q    <= 1'b0;
      inv_seen_q <= 1'b0;
      m_raddr_q  <= '0;
      m_rreq_q   <= 2'b00;
      m_waddr_q  <= '0;
      m_wmask_q  <= 2'b00;
      m_wdata_q  <= '0;
    end else begin
      // NOTE: non-blocking only; these pulse defaults are overridden by later assignments below.
      rdone_q <= 1'b0;
      wdone_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (cpu.wmask != 2'b00) begin
            m_waddr_q <= cpu.waddr;
            m_wmask_q <= cpu.wmask;
            m_wdata_q <= cpu.wdata;
            state_q   <= S_WRITE;
          end else if (cpu.rreq != 2'b00) begin
            if (hit) begin
              rdata_q <= hit_data;
              rdone_q <= 1'b1;
              state_q <= S_DONE;
            end else begin
              m_raddr_q  <= cpu.raddr;
              m_rreq_q   <= 2'b11;
              inv_seen_q <= 1'b0;
              state_q    <= S_MISS;
            end
          end
        end
        S_MISS: begin
          if (inv) inv_seen_q <= 1'b1;
          if (mem.rdone) begin
            m_rreq_q <= 2'b00;
            rdata_q  <= mem.rdata;
            rdone_q  <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_WRITE: begin
          if (mem.wdone) begin
            m_wmask_q <= 2'b00;
            wdone_q   <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cpu.rdata = rdata_q;
  assign cpu.rdone = rdone_q;
  assign cpu.wdone = wdone_q;
  assign mem.raddr = m_raddr_q;
  assign mem.rreq  = m_rreq_q;
  assign mem.waddr = m_waddr_q;
  assign mem.wmask = m_wmask_q;
  assign mem.wdata = m_wdata_q;

endmodule

// File: doc/vc32_rcache.md
VC32_RCACHE -- requirements
Module: vc32_rcache

Interface
REQ-001 SHALL have parameter RV, default 16, memory word width in bits; only RV=16 is supported.
REQ-002 SHALL have parameter LINES, default 8, number of direct-mapped one-word lines (power of two, 2..16).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_in  input  1  synchronous, active-high reset.
REQ-005 inv  input  1  one-cycle pulse; invalidate all lines.
REQ-006 raddr  input  15  CPU read word address [15:1].
REQ-007 rreq  input  2  CPU byte read request (bit0 low byte, bit1 high byte), held until rdone.
REQ-008 rdata  output  16  read data to CPU.
REQ-009 rdone  output  1  one-cycle read-complete pulse to CPU.
REQ-010 waddr  input  15  CPU write word address [15:1].
REQ-011 wmask  input  2  CPU byte write enables, held until wdone.
REQ-012 wdata  input  16  CPU write data.
REQ-013 wdone  output  1  one-cycle write-complete pulse to CPU.
REQ-014 m_raddr / m_rreq / m_rdata / m_rdone  out 15 / out 2 / in 16 / in 1  downstream read port to the byte-serial bus sequencer, same protocol as the CPU port.
REQ-015 m_waddr / m_wmask / m_wdata / m_wdone  out 15 / out 2 / out 16 / in 1  downstream write port, same protocol.

Function
REQ-016 SHALL split word address as index = addr[log2(LINES):1], tag = addr[15:log2(LINES)+1]; each line holds valid, tag, 16-bit data.
REQ-017 SHALL run FSM IDLE, MISS, WRITE, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-018 In IDLE, wmask!=0 SHALL take priority over rreq!=0 when both are nonzero.
REQ-019 IDLE with write: register m_waddr=waddr, m_wmask=wmask, m_wdata=wdata, go WRITE.
REQ-020 WRITE: hold m_* write outputs until m_wdone=1; in that cycle clear m_wmask, update bytes selected by wmask in the indexed line only if valid and tag match (no allocate), set wdone, go DONE.
REQ-021 IDLE with read hit: register rdata=line data, set rdone, go DONE (rdone high the cycle after request first seen).
REQ-022 IDLE with read miss: register m_raddr=raddr, m_rreq=2'b11 regardless of rreq, go MISS.
REQ-023 MISS: hold m_rreq until m_rdone=1; in that cycle clear m_rreq, write m_rdata into line with tag, set valid, register rdata=m_rdata, set rdone, go DONE.
REQ-024 rdone and wdone SHALL be high only in DONE, never both; in DONE no new request is accepted.
REQ-025 inv SHALL clear all valid bits in the cycle it is seen; if seen during MISS, the fill still returns rdata/rdone but the line SHALL remain invalid.
REQ-026 inv coincident with a hit in IDLE: the hit SHALL be served from pre-invalidation contents.
REQ-027 m_rreq and m_wmask SHALL never be nonzero simultaneously.
REQ-028 rdata SHALL hold its last value outside DONE.

Reset
REQ-029 reset_in=1 SHALL force state IDLE, all valid bits 0, rdone=0, wdone=0, m_rreq=0, m_wmask=0, rdata=0, m_raddr=0, m_waddr=0, m_wdata=0, overriding every other input.
REQ-030 Reset during MISS or WRITE SHALL abandon the transaction without a done pulse; the sequencer is reset by the same signal.
REQ-031 Tag/data contents need no reset value; only valid bits are reset.

Structure
REQ-032 RV, FSM state encodings and index/tag width functions SHALL live in the shared vc32 package/include.
REQ-033 Line storage (valid, tag, data arrays, byte-masked write, combinational lookup) SHALL be sub-module vc32_rcache_store; FSM and port registers stay in vc32_rcache.

Verification
REQ-034 Reset, read 0x0010 rreq=11, m_rdata=0xBEEF after 6 cycles -> m_rreq=11 until m_rdone, rdone one cycle later with rdata=0xBEEF.
REQ-035 Repeat read 0x0010 rreq=01 -> rdone the next cycle, rdata=0xBEEF, m_rreq stays 0.
REQ-036 Write 0x0010 wmask=10 wdata=0x12xx -> m_wmask=10 until m_wdone, wdone pulse; then read 0x0010 hits with 0x12EF.
REQ-037 Read 0x0020 (same index LINES=8, different tag) -> miss, refill, subsequent 0x0010 read misses.
REQ-038 Simultaneous wmask=01 and rreq=11 -> write completes first, then read; inv pulse mid-MISS -> rdone given, next read same address misses.
REQ-039 reset_in asserted mid-MISS -> all outputs 0 next cycle, no rdone, prior hit address now misses.
